button_conditioner: RTL and testbench

//  - Upstream stage of led_cycle; drives its buttons[4:0] speed-select input.
//  - Synchronises and debounces 5 raw Basys3 push-buttons.
//  - Emits a one-cycle press pulse per button and a latched one-hot speed selection.
//  - Selection holds after release, so LED sweep speed persists without holding a button.

---
 rtl/led_pkg.sv | 10 +
 rtl/debounce_cell.sv | 40 ++++
 rtl/button_conditioner.sv | 34 +++
 tb/tb_button_conditioner.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: button vector type and speed encodings shared by button_conditioner and led_cycle.
package led_pkg;
  localparam int NUM_BTN = 5;
  typedef logic [NUM_BTN-1:0] btn_vec_t;
  localparam btn_vec_t SPEED_SLOWEST = 5'b00001;
  localparam btn_vec_t SPEED_FASTEST = 5'b10000;
  function automatic btn_vec_t lowest_one(input btn_vec_t v);
    return v & (~v + btn_vec_t'(1));
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one-bit 2-flop synchroniser, debounce counter, stable level and rise pulse.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic rise_next
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic meta_q, sync_q, stable_q, stable_d, rise_q, differ, done;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    differ    = sync_q != stable_q;
    done      = differ && cnt_q == LAST;
    cnt_d     = (!differ || done) ? '0 : cnt_q + CW'(1);
    stable_d  = done ? sync_q : stable_q;
    rise_next = done && sync_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_next;
    end
  end
  assign stable = stable_q;
  assign rise   = rise_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces the push-buttons and latches a one-hot speed selection,
// lowest-index newly pressed button winning.
module button_conditioner
  import led_pkg::*;
#(
  parameter int       DEBOUNCE_CYCLES = 500000,
  parameter btn_vec_t DEFAULT_SEL     = SPEED_SLOWEST
) (
  input  logic     clk,
  input  logic     rst_n,
  input  btn_vec_t buttons_raw,
  output btn_vec_t buttons_stable,
  output btn_vec_t press_pulse,
  output btn_vec_t speed_sel
);
  btn_vec_t rise_next, sel_q, sel_d;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (buttons_raw[i]),
      .stable    (buttons_stable[i]),
      .rise      (press_pulse[i]),
      .rise_next (rise_next[i])
    );
  end
  // Selection updates on the same edge the registered pulse rises.
  always_comb sel_d = |rise_next ? lowest_one(rise_next) : sel_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sel_q <= DEFAULT_SEL;
    else        sel_q <= sel_d;
  end
  assign speed_sel = sel_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus random stimulus against a sample-window model.
module tb_button_conditioner;
  import led_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  btn_vec_t raw = '0, stab, pulse, sel;
  int checks = 0, errors = 0;
  btn_vec_t hist[$], samples[$];
  int last_chg[NUM_BTN];
  btn_vec_t m_stable = '0, m_pulse = '0, m_sel = SPEED_SLOWEST, prev_pulse = '0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .DEFAULT_SEL(SPEED_SLOWEST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .buttons_raw    (raw),
    .buttons_stable (stab),
    .press_pulse    (pulse),
    .speed_sel      (sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sync sample at an edge is raw from two edges earlier; a level is accepted once the
  // last D samples since the previous change all disagree with it.
  task automatic tick();
    btn_vec_t sp, rise;
    int n;
    bit ok;
    @(posedge clk);
    rise = '0;
    if (!rst_n) begin
      hist = '{btn_vec_t'(0), btn_vec_t'(0)};
      samples.delete();
      foreach (last_chg[i]) last_chg[i] = 0;
      m_stable = '0;
      m_pulse = '0;
      m_sel = SPEED_SLOWEST;
    end else begin
      sp = hist.pop_front();
      hist.push_back(raw);
      samples.push_back(sp);
      n = samples.size();
      for (int i = 0; i < NUM_BTN; i++) begin
        if (n - last_chg[i] >= D) begin
          ok = 1'b1;
          for (int k = n - D; k < n; k++) if (samples[k][i] == m_stable[i]) ok = 1'b0;
          if (ok) begin
            m_stable[i] = ~m_stable[i];
            last_chg[i] = n;
            rise[i] = m_stable[i];
          end
        end
      end
      m_pulse = rise;
      for (int i = NUM_BTN - 1; i >= 0; i--) if (rise[i]) m_sel = btn_vec_t'(1) << i;
    end
    #1;
    chk("stable", stab, m_stable);
    chk("pulse", pulse, m_pulse);
    chk("sel", sel, m_sel);
    chk("sel_onehot", 32'($onehot(sel)), 1);
    chk("pulse_1cyc", pulse & prev_pulse, 0);
    prev_pulse = pulse;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    hist = '{btn_vec_t'(0), btn_vec_t'(0)};
    rst_n = 1'b0;
    ticks(2);
    chk("rst_stable", stab, 0);
    chk("rst_sel", sel, 5'b00001);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t1_stable", stab, 0);
      chk("t1_pulse", pulse, 0);
      chk("t1_sel", sel, 5'b00001);
    end
    raw = 5'b00100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t2_rise_stable", stab, k == 6 ? 5'b00100 : 5'b00000);
      chk("t2_rise_pulse", pulse, k == 6 ? 5'b00100 : 5'b00000);
    end
    chk("t2_sel", sel, 5'b00100);
    tick();
    chk("t2_pulse_drop", pulse, 0);
    ticks(3);
    raw = 5'b00000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t2_fall_stable", stab, k == 6 ? 5'b00000 : 5'b00100);
      chk("t2_fall_pulse", pulse, 0);
      chk("t2_hold_sel", sel, 5'b00100);
    end
    for (int k = 0; k < 14; k++) begin
      raw = (k < 8 && k % 4 != 3) ? 5'b01000 : 5'b00000;
      tick();
      chk("t3_stable", stab, 0);
      chk("t3_pulse", pulse, 0);
      chk("t3_sel", sel, 5'b00100);
    end
    raw = 5'b10010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t4_pulse", pulse, k == 6 ? 5'b10010 : 5'b00000);
    end
    chk("t4_sel", sel, 5'b00010);
    tick();
    chk("t4_pulse_drop", pulse, 0);
    raw = 5'b00000;
    ticks(8);
    chk("t4_released", stab, 0);
    raw = 5'b10000;
    ticks(4);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_stable", stab, 0);
    chk("t5_rst_pulse", pulse, 0);
    chk("t5_rst_sel", sel, 5'b00001);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t5_stable", stab, k == 6 ? 5'b10000 : 5'b00000);
    end
    chk("t5_pulse", pulse, 5'b10000);
    chk("t5_sel", sel, 5'b10000);
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NUM_BTN; i++) if ($urandom_range(7) == 0) raw[i] = ~raw[i];
      rst_n = $urandom_range(1999) != 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
